mux_sel_arbiter: RTL and testbench

- Two-requester round-robin arbiter that drives the select input of the downstream behavioural 2:1 mux (sel=0 routes in1, sel=1 routes in2).
- Decides which source owns the mux output and holds the grant for a bounded burst.
- Replaces hand-driven sel stimulus with registered, handshake-controlled selection.
- Sits directly upstream of mux_behav; its sel output connects to the mux sel port.

---
 rtl/mux_sel_arbiter_if.sv | 23 ++
 rtl/mux_sel_arbiter.sv | 110 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the requesters and the mux select arbiter.
// The master side raises requests; the slave side (arbiter) returns the grant state.
interface mux_sel_arbiter_if #(
    parameter int unsigned CNT_W = 4
);
    logic             req0;
    logic             req1;
    logic             sel;
    logic             gnt0;
    logic             gnt1;
    logic             valid;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        output req0, req1,
        input  sel, gnt0, gnt1, valid, hold_cnt
    );

    modport slave (
        input  req0, req1,
        output sel, gnt0, gnt1, valid, hold_cnt
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the 2:1 mux select (0 = in1, 1 = in2).
// A contested owner is forced off after MAX_HOLD cycles; an unopposed owner keeps the grant.
module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux_sel_arbiter_if.slave    bus
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             valid_q, valid_d;

    // State and registered outputs; reset wins over everything, including X requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            valid_q <= valid_d;
        end
    end

    // Next-state and next-output decode; hold count restarts on any owner change or idle.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = '0;
        sel_d   = sel_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 && !bus.req1) begin
                    state_d = GRANT0;
                end else if (!bus.req0 && bus.req1) begin
                    state_d = GRANT1;
                end else if (bus.req0 && bus.req1) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                end
            end
            GRANT0: begin
                if (!bus.req0) begin
                    state_d = bus.req1 ? GRANT1 : IDLE;
                end else if (bus.req1 && (cnt_q == HOLD_LAST)) begin
                    state_d = GRANT1;
                end else begin
                    cnt_d = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            GRANT1: begin
                if (!bus.req1) begin
                    state_d = bus.req0 ? GRANT0 : IDLE;
                end else if (bus.req0 && (cnt_q == HOLD_LAST)) begin
                    state_d = GRANT0;
                end else begin
                    cnt_d = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt0_d  = (state_d == GRANT0);
        gnt1_d  = (state_d == GRANT1);
        valid_d = gnt0_d | gnt1_d;

        // sel only moves on a grant so the mux output stays put through idle gaps.
        if (gnt0_d) begin
            sel_d  = 1'b0;
            last_d = 1'b0;
        end else if (gnt1_d) begin
            sel_d  = 1'b1;
            last_d = 1'b1;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.valid    = valid_q;
    assign bus.hold_cnt = cnt_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: default MAX_HOLD=8 build plus a MAX_HOLD=1 build
// feeding a behavioural 2:1 mux model.
module tb_mux_sel_arbiter;
    logic clk;
    logic rst;
    logic rst1;
    int   n_cmp;
    int   n_err;

    mux_sel_arbiter_if #(.CNT_W(4)) bus_a ();
    mux_sel_arbiter_if #(.CNT_W(4)) bus_b ();

    mux_sel_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mux_sel_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {gnt0, gnt1, sel, valid, hold_cnt}.
    function automatic logic [7:0] snap_a();
        return {bus_a.gnt0, bus_a.gnt1, bus_a.sel, bus_a.valid, bus_a.hold_cnt};
    endfunction

    function automatic logic [7:0] snap_b();
        return {bus_b.gnt0, bus_b.gnt1, bus_b.sel, bus_b.valid, bus_b.hold_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1;
        bus_a.req0 = 1'bx;
        bus_a.req1 = 1'bx;
        tick();
        bus_a.req0 = 1'b1;
        bus_a.req1 = 1'b1;
        tick();
        exp = 8'b0000_0000;
        n_cmp++;
        if (snap_a() !== exp) begin
            n_err++;
            $display("FAIL reset_values: got %b expected %b", snap_a(), exp);
        end
        rst = 1'b0;
        tick();
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        n_cmp++;
        if (snap_a() !== exp) begin
            n_err++;
            $display("FAIL reset_first_grant: got %b expected %b", snap_a(), exp);
        end
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        tick();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        n_cmp++;
        if (snap_a() !== exp) begin
            n_err++;
            $display("FAIL reset_release_idle: got %b expected %b", snap_a(), exp);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp;
        bus_a.req1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp = {1'b0, 1'b1, 1'b1, 1'b1, 4'((i < 7) ? i : 7)};
            n_cmp++;
            if (snap_a() !== exp) begin
                n_err++;
                $display("FAIL single_cycle%0d: got %b expected %b", i, snap_a(), exp);
            end
        end
        bus_a.req1 = 1'b0;
        tick();
        exp = {1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        n_cmp++;
        if (snap_a() !== exp) begin
            n_err++;
            $display("FAIL single_drop_sel_holds: got %b expected %b", snap_a(), exp);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp;
        int         owner;
        // Last owner was port 1, so port 0 wins the tie out of idle.
        bus_a.req0 = 1'b1;
        bus_a.req1 = 1'b1;
        for (int c = 0; c < 32; c++) begin
            tick();
            owner = (c / 8) % 2;
            exp = {owner == 0, owner == 1, owner == 1, 1'b1, 4'(c % 8)};
            n_cmp++;
            if (snap_a() !== exp) begin
                n_err++;
                $display("FAIL contention_cycle%0d: got %b expected %b", c, snap_a(), exp);
            end
        end
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        tick();
        exp = {1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        n_cmp++;
        if (snap_a() !== exp) begin
            n_err++;
            $display("FAIL contention_release: got %b expected %b", snap_a(), exp);
        end
    endtask

    task automatic test_handover();
        logic [7:0] exp;
        bus_a.req0 = 1'b1;
        repeat (4) tick();
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 4'd3};
        n_cmp++;
        if (snap_a() !== exp) begin
            n_err++;
            $display("FAIL handover_setup: got %b expected %b", snap_a(), exp);
        end
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b1;
        tick();
        exp = {1'b0, 1'b1, 1'b1, 1'b1, 4'd0};
        n_cmp++;
        if (snap_a() !== exp) begin
            n_err++;
            $display("FAIL handover_switch: got %b expected %b", snap_a(), exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        repeat (5) tick();
        exp = {1'b0, 1'b1, 1'b1, 1'b1, 4'd5};
        n_cmp++;
        if (snap_a() !== exp) begin
            n_err++;
            $display("FAIL reset_mid_setup: got %b expected %b", snap_a(), exp);
        end
        bus_a.req0 = 1'b1;
        rst = 1'b1;
        tick();
        exp = 8'b0000_0000;
        n_cmp++;
        if (snap_a() !== exp) begin
            n_err++;
            $display("FAIL reset_mid_values: got %b expected %b", snap_a(), exp);
        end
        rst = 1'b0;
        tick();
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        n_cmp++;
        if (snap_a() !== exp) begin
            n_err++;
            $display("FAIL reset_mid_regrant: got %b expected %b", snap_a(), exp);
        end
        tick();
        exp = {1'b1, 1'b0, 1'b0, 1'b1, 4'd1};
        n_cmp++;
        if (snap_a() !== exp) begin
            n_err++;
            $display("FAIL reset_mid_count: got %b expected %b", snap_a(), exp);
        end
    endtask

    task automatic test_max_hold1();
        logic [7:0] exp;
        logic       in1;
        logic       in2;
        logic       mux_out;
        in1 = 1'b0;
        in2 = 1'b1;
        bus_b.req0 = 1'b1;
        bus_b.req1 = 1'b1;
        rst1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {(i % 2) == 0, (i % 2) == 1, 1'((i % 2)), 1'b1, 4'd0};
            n_cmp++;
            if (snap_b() !== exp) begin
                n_err++;
                $display("FAIL hold1_cycle%0d: got %b expected %b", i, snap_b(), exp);
            end
            mux_out = bus_b.sel ? in2 : in1;
            n_cmp++;
            if (mux_out !== 1'((i % 2))) begin
                n_err++;
                $display("FAIL hold1_mux_out%0d: got %b expected %b", i, mux_out, 1'((i % 2)));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        rst1  = 1'b1;
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        bus_b.req0 = 1'b0;
        bus_b.req1 = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_handover();
        test_reset_mid();
        test_max_hold1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
